// File: rtl/xiyiji_motor_drive.sv
// H-bridge gate driver with dead-time-enforced reversals, soft-start PWM and emergency trip.
// Optional build macro XIYIJI_MOTOR_BRAKE_EN: low-side braking during DEAD instead of coasting.
module xiyiji_motor_drive #(
   parameter int DEAD_TICKS      = 5,
   parameter int RAMP_STEP_TICKS = 2,
   parameter int PWM_BITS        = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                zheng,
   input  logic                fan,
   input  logic                emergency,
   output logic                hs_a,
   output logic                ls_a,
   output logic                hs_b,
   output logic                ls_b,
   output logic                running,
   output logic                dir_fault,
   output logic [PWM_BITS-1:0] duty
);

   localparam int DW = $clog2(DEAD_TICKS + 1);
   localparam int RW = (RAMP_STEP_TICKS > 1) ? $clog2(RAMP_STEP_TICKS) : 1;
   localparam logic [DW-1:0]       DEAD_LOAD = DW'(DEAD_TICKS);
   localparam logic [RW-1:0]       RAMP_LAST = RW'(RAMP_STEP_TICKS - 1);
   localparam logic [PWM_BITS-1:0] DUTY_MIN  = PWM_BITS'(1);
   localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;

   typedef enum logic [2:0] {S_IDLE, S_FWD, S_REV, S_DEAD, S_TRIP} state_e;

   state_e              state_q, state_d;
   logic [DW-1:0]       dead_q, dead_d;
   logic [RW-1:0]       ramp_q, ramp_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic                both_q, both_d;
   logic                dir_fault_q, dir_fault_d;

   logic cmd_fwd, cmd_rev, cmd_both, pwm;

   assign cmd_fwd  = zheng & ~fan;
   assign cmd_rev  = fan & ~zheng;
   assign cmd_both = zheng & fan;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         dead_q      <= '0;
         ramp_q      <= '0;
         duty_q      <= '0;
         pwm_cnt_q   <= '0;
         both_q      <= 1'b0;
         dir_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dead_q      <= dead_d;
         ramp_q      <= ramp_d;
         duty_q      <= duty_d;
         pwm_cnt_q   <= pwm_cnt_d;
         both_q      <= both_d;
         dir_fault_q <= dir_fault_d;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      dead_d  = dead_q;
      if (emergency) begin
         state_d = S_TRIP;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cmd_fwd)      state_d = S_FWD;
               else if (cmd_rev) state_d = S_REV;
            end
            S_FWD: begin
               if (!cmd_fwd) begin
                  state_d = S_DEAD;
                  dead_d  = DEAD_LOAD;
               end
            end
            S_REV: begin
               if (!cmd_rev) begin
                  state_d = S_DEAD;
                  dead_d  = DEAD_LOAD;
               end
            end
            S_DEAD: begin
               // Counter value 1 marks the last DEAD cycle.
               if (dead_q > DW'(1)) begin
                  dead_d = dead_q - 1'b1;
               end else begin
                  dead_d  = '0;
                  state_d = S_IDLE;
               end
            end
            S_TRIP: begin
               state_d = S_DEAD;
               dead_d  = DEAD_LOAD;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      ramp_d = '0;
      duty_d = '0;
      if (state_d == S_FWD || state_d == S_REV) begin
         if (state_q != state_d) begin
            duty_d = DUTY_MIN;
         end else if (ramp_q == RAMP_LAST) begin
            duty_d = (duty_q == DUTY_MAX) ? duty_q : duty_q + 1'b1;
         end else begin
            ramp_d = ramp_q + 1'b1;
            duty_d = duty_q;
         end
      end
      pwm_cnt_d   = pwm_cnt_q + 1'b1;
      both_d      = cmd_both;
      dir_fault_d = cmd_both & ~both_q;
   end

   assign pwm = (pwm_cnt_q < duty_q);

   // Each leg has at most one gate driven in every state, so shoot-through is impossible.
   always_comb begin
      hs_a = 1'b0;
      ls_a = 1'b0;
      hs_b = 1'b0;
      ls_b = 1'b0;
      case (state_q)
         S_FWD: begin
            hs_a = pwm;
            ls_b = 1'b1;
         end
         S_REV: begin
            hs_b = pwm;
            ls_a = 1'b1;
         end
         S_DEAD: begin
`ifdef XIYIJI_MOTOR_BRAKE_EN
            ls_a = 1'b1;
            ls_b = 1'b1;
`else
            ls_a = 1'b0;
            ls_b = 1'b0;
`endif
         end
         default: ;
      endcase
   end

   assign running   = (state_q == S_FWD) || (state_q == S_REV);
   assign dir_fault = dir_fault_q;
   assign duty      = duty_q;

endmodule

// File: tb/tb_xiyiji_motor_drive.sv
// Directed self-checking bench for xiyiji_motor_drive (DEAD_TICKS=5, RAMP_STEP_TICKS=2, PWM_BITS=4).
// Expectations adapt to XIYIJI_MOTOR_BRAKE_EN when the bench is built with that macro.
module tb_xiyiji_motor_drive;

   logic       clk = 1'b0;
   logic       rst, zheng, fan, emergency;
   logic       hs_a, ls_a, hs_b, ls_b, running, dir_fault;
   logic [3:0] duty;
   logic [3:0] gates;

   int errors = 0;
   int checks = 0;
   int hi_cnt;

`ifdef XIYIJI_MOTOR_BRAKE_EN
   localparam logic [3:0] DEAD_GATES = 4'b0101;
`else
   localparam logic [3:0] DEAD_GATES = 4'b0000;
`endif

   xiyiji_motor_drive #(
      .DEAD_TICKS      (5),
      .RAMP_STEP_TICKS (2),
      .PWM_BITS        (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .zheng     (zheng),
      .fan       (fan),
      .emergency (emergency),
      .hs_a      (hs_a),
      .ls_a      (ls_a),
      .hs_b      (hs_b),
      .ls_b      (ls_b),
      .running   (running),
      .dir_fault (dir_fault),
      .duty      (duty)
   );

   always #5 clk = ~clk;

   // Gate vector order: {hs_a, ls_a, hs_b, ls_b}.
   assign gates = {hs_a, ls_a, hs_b, ls_b};

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check("shoot_through", {7'd0, (hs_a & ls_a) | (hs_b & ls_b)}, 8'd0);
      end
   endtask

   initial begin
      rst = 1'b1; zheng = 1'b1; fan = 1'b0; emergency = 1'b0;

      // 1. reset with zheng held, then release
      tick(3);
      check("rst_gates",   {4'd0, gates}, 8'h00);
      check("rst_duty",    {4'd0, duty}, 8'd0);
      check("rst_running", {7'd0, running}, 8'd0);
      check("rst_fault",   {7'd0, dir_fault}, 8'd0);
      rst = 1'b0;
      tick(1);
      check("start_running", {7'd0, running}, 8'd1);
      check("start_duty",    {4'd0, duty}, 8'd1);
      check("start_legs",    {5'd0, ls_a, hs_b, ls_b}, 8'b001);

      // 2. soft-start ramp to saturation
      tick(1);  check("ramp_1",  {4'd0, duty}, 8'd1);
      tick(1);  check("ramp_2",  {4'd0, duty}, 8'd2);
      tick(25); check("ramp_14", {4'd0, duty}, 8'd14);
      tick(1);  check("ramp_15", {4'd0, duty}, 8'd15);
      hi_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         tick(1);
         if (hs_a) hi_cnt++;
      end
      check("pwm_high_of_16", 8'(hi_cnt), 8'd15);
      check("ramp_hold",      {4'd0, duty}, 8'd15);
      check("fwd_ls_b",       {7'd0, ls_b}, 8'd1);

      // 3. reversal through dead time
      zheng = 1'b0; fan = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("rev_dead_gates", {4'd0, gates}, {4'd0, DEAD_GATES});
         check("rev_dead_run",   {7'd0, running}, 8'd0);
         check("rev_dead_duty",  {4'd0, duty}, 8'd0);
      end
      tick(1);
      check("rev_idle_gates", {4'd0, gates}, 8'h00);
      check("rev_idle_run",   {7'd0, running}, 8'd0);
      tick(1);
      check("rev_running", {7'd0, running}, 8'd1);
      check("rev_duty",    {4'd0, duty}, 8'd1);
      check("rev_legs",    {5'd0, hs_a, ls_a, ls_b}, 8'b010);

      // 4. both commands from FWD
      zheng = 1'b1; fan = 1'b0;
      tick(7);
      check("fwd_again_run",  {7'd0, running}, 8'd1);
      check("fwd_again_ls_b", {7'd0, ls_b}, 8'd1);
      fan = 1'b1;
      tick(1);
      check("both_fault_pulse", {7'd0, dir_fault}, 8'd1);
      check("both_run",         {7'd0, running}, 8'd0);
      check("both_dead_gates",  {4'd0, gates}, {4'd0, DEAD_GATES});
      tick(1);
      check("both_fault_clear", {7'd0, dir_fault}, 8'd0);
      tick(2);
      check("both_fault_once",  {7'd0, dir_fault}, 8'd0);
      zheng = 1'b0; fan = 1'b0;
      tick(1);
      check("both_dead_last",  {4'd0, gates}, {4'd0, DEAD_GATES});
      tick(1);
      check("both_idle_gates", {4'd0, gates}, 8'h00);
      tick(2);
      check("both_idle_run",   {7'd0, running}, 8'd0);
      check("both_idle_fault", {7'd0, dir_fault}, 8'd0);

      // 5. emergency trip mid-FWD
      zheng = 1'b1;
      tick(4);
      check("pre_trip_duty", {4'd0, duty}, 8'd2);
      emergency = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("trip_gates", {4'd0, gates}, 8'h00);
         check("trip_run",   {7'd0, running}, 8'd0);
         check("trip_duty",  {4'd0, duty}, 8'd0);
      end
      emergency = 1'b0; zheng = 1'b0; fan = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("trip_dead_gates", {4'd0, gates}, {4'd0, DEAD_GATES});
         check("trip_dead_run",   {7'd0, running}, 8'd0);
      end
      tick(1);
      check("trip_idle_gates", {4'd0, gates}, 8'h00);
      check("trip_idle_run",   {7'd0, running}, 8'd0);
      tick(1);
      check("trip_rev_run",  {7'd0, running}, 8'd1);
      check("trip_rev_ls_a", {7'd0, ls_a}, 8'd1);

      // reset mid-REV: no dead interval on exit
      tick(3);
      rst = 1'b1;
      tick(1);
      check("midrst_gates", {4'd0, gates}, 8'h00);
      check("midrst_run",   {7'd0, running}, 8'd0);
      check("midrst_duty",  {4'd0, duty}, 8'd0);
      rst = 1'b0;
      tick(1);
      check("postrst_run",  {7'd0, running}, 8'd1);
      check("postrst_duty", {4'd0, duty}, 8'd1);
      check("postrst_ls_a", {7'd0, ls_a}, 8'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
